reg_status_ctrl: RTL



---
 rtl/reg_status_ctrl_pkg.sv | 23 ++
 rtl/reg_array.sv | 45 ++++
 rtl/reg_status_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/reg_status_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_status_ctrl_pkg
// Description : Shared widths and the operand-lookup bundle for the
//               register-status controller and its register array.
// Revision    : 1.0 - initial release
// ============================================================================
package reg_status_ctrl_pkg;

    localparam int XLEN       = 32;
    localparam int TAG_W      = 4;
    localparam int REG_NUM    = 32;
    localparam int REG_ADDR_W = $clog2(REG_NUM);

    // Result of one source-operand lookup as seen by a reservation station.
    typedef struct packed {
        logic             ready;
        logic [XLEN-1:0]  value;
        logic [TAG_W-1:0] tag;
    } reg_lookup_t;

endpackage
`default_nettype wire

// File: rtl/reg_array.sv
`default_nettype none
// ============================================================================
// Module      : reg_array
// Description : Architectural register storage, two combinational read
//               ports and one synchronous write port. x0 always reads zero
//               and is never written.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_array
    import reg_status_ctrl_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_we,
    input  logic [REG_ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0]     i_wdata,
    input  logic [REG_ADDR_W-1:0] i_raddr1,
    output logic [DATA_W-1:0]     o_rdata1,
    input  logic [REG_ADDR_W-1:0] i_raddr2,
    output logic [DATA_W-1:0]     o_rdata2
);

    logic [DATA_W-1:0] r_mem [REG_NUM];

    // Storage: cleared on reset, written by the commit port (never x0).
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we && (i_waddr != '0)) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read ports: x0 forced to zero regardless of storage contents.
    always_comb begin
        o_rdata1 = (i_raddr1 == '0) ? '0 : r_mem[i_raddr1];
        o_rdata2 = (i_raddr2 == '0) ? '0 : r_mem[i_raddr2];
    end

endmodule
`default_nettype wire

// File: rtl/reg_status_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : reg_status_ctrl
// Description : Register-status and access controller. Tracks per-register
//               busy/tag state for in-flight ROB producers, answers two
//               source lookups per dispatch (with same-cycle commit bypass)
//               and takes the ROB commit write into the register array.
//               XLEN/TAG_W must match the package widths used by the lookup
//               bundle.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_status_ctrl #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             flush_in,
    input  logic             issue_valid,
    input  logic [4:0]       issue_rs1,
    input  logic [4:0]       issue_rs2,
    input  logic [4:0]       issue_rd,
    input  logic [TAG_W-1:0] issue_tag,
    input  logic             commit_valid,
    input  logic [4:0]       commit_rd,
    input  logic [TAG_W-1:0] commit_tag,
    input  logic [XLEN-1:0]  commit_data,
    output logic             out_valid,
    output logic             rs1_ready,
    output logic [XLEN-1:0]  rs1_value,
    output logic [TAG_W-1:0] rs1_tag,
    output logic             rs2_ready,
    output logic [XLEN-1:0]  rs2_value,
    output logic [TAG_W-1:0] rs2_tag
);
    import reg_status_ctrl_pkg::*;

    logic [REG_NUM-1:0] r_busy;
    logic [TAG_W-1:0]   r_tag [REG_NUM];

    logic               r_out_valid;
    reg_lookup_t        r_rs1;
    reg_lookup_t        r_rs2;

    logic [XLEN-1:0]    w_rdata1;
    logic [XLEN-1:0]    w_rdata2;
    logic               w_reg_we;
    logic               w_issue_dst;
    logic               w_commit_clear;
    reg_lookup_t        w_rs1_lu;
    reg_lookup_t        w_rs2_lu;

    // The data write only waits on pause; reset is handled inside the array.
    assign w_reg_we = rdy_in && commit_valid && (commit_rd != 5'd0);

    reg_array #(
        .DATA_W (XLEN)
    ) u_reg_array (
        .clk      (clk_in),
        .rst      (rst_in),
        .i_we     (w_reg_we),
        .i_waddr  (commit_rd),
        .i_wdata  (commit_data),
        .i_raddr1 (issue_rs1),
        .o_rdata1 (w_rdata1),
        .i_raddr2 (issue_rs2),
        .o_rdata2 (w_rdata2)
    );

    // Source lookup against pre-update state; a matching commit this cycle
    // supplies the value directly so the operand is not left waiting.
    function automatic reg_lookup_t lookup_src(
        input logic [4:0]       rs,
        input logic [XLEN-1:0]  rdata,
        input logic             busy,
        input logic [TAG_W-1:0] tag,
        input logic             c_valid,
        input logic [4:0]       c_rd,
        input logic [TAG_W-1:0] c_tag,
        input logic [XLEN-1:0]  c_data
    );
        reg_lookup_t lu;
        lu = '0;
        if (rs == 5'd0) begin
            lu.ready = 1'b1;
        end else if (busy) begin
            if (c_valid && (c_rd == rs) && (c_tag == tag)) begin
                lu.ready = 1'b1;
                lu.value = c_data;
            end else begin
                lu.tag = tag;
            end
        end else begin
            lu.ready = 1'b1;
            lu.value = rdata;
        end
        return lu;
    endfunction

    // Combinational lookups and busy-table update decisions.
    always_comb begin
        w_rs1_lu = lookup_src(issue_rs1, w_rdata1, r_busy[issue_rs1], r_tag[issue_rs1],
                              commit_valid, commit_rd, commit_tag, commit_data);
        w_rs2_lu = lookup_src(issue_rs2, w_rdata2, r_busy[issue_rs2], r_tag[issue_rs2],
                              commit_valid, commit_rd, commit_tag, commit_data);
        w_issue_dst    = issue_valid && (issue_rd != 5'd0);
        // A newer producer issued to the same rd keeps the register busy.
        w_commit_clear = commit_valid && (commit_rd != 5'd0) &&
                         (r_tag[commit_rd] == commit_tag) &&
                         !(w_issue_dst && (issue_rd == commit_rd));
    end

    // Busy/tag table and registered lookup outputs.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_busy      <= '0;
            for (int i = 0; i < REG_NUM; i++) begin
                r_tag[i] <= '0;
            end
            r_out_valid <= 1'b0;
            r_rs1       <= '0;
            r_rs2       <= '0;
        end else if (rdy_in) begin
            if (flush_in) begin
                r_busy      <= '0;
                r_out_valid <= 1'b0;
            end else begin
                if (w_commit_clear) begin
                    r_busy[commit_rd] <= 1'b0;
                end
                if (w_issue_dst) begin
                    r_busy[issue_rd] <= 1'b1;
                    r_tag[issue_rd]  <= issue_tag;
                end
                r_out_valid <= issue_valid;
                if (issue_valid) begin
                    r_rs1 <= w_rs1_lu;
                    r_rs2 <= w_rs2_lu;
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign rs1_ready = r_rs1.ready;
    assign rs1_value = r_rs1.value;
    assign rs1_tag   = r_rs1.tag;
    assign rs2_ready = r_rs2.ready;
    assign rs2_value = r_rs2.value;
    assign rs2_tag   = r_rs2.tag;

endmodule
`default_nettype wire
